// File: rtl/nv_nvdla_cmac_op_seq.sv
// CMAC layer sequencer: serves the d0/d1 register groups in strict alternation,
// shadows the active group's config, drives op_en to the core, retires layers
// on done or watchdog timeout and keeps the layer count and sticky error.
module nv_nvdla_cmac_op_seq #(
    parameter int GAP_CYCLES = 3,
    parameter int WDOG_W     = 20,
    parameter int CNT_W      = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             reg2dp_d0_op_en,
    input  logic             reg2dp_d1_op_en,
    input  logic             reg2dp_d0_conv_mode,
    input  logic             reg2dp_d1_conv_mode,
    input  logic [1:0]       reg2dp_d0_proc_precision,
    input  logic [1:0]       reg2dp_d1_proc_precision,
    input  logic             dp2reg_done,
    input  logic             wdog_en,
    input  logic             err_clr,
    output logic             reg2dp_op_en,
    output logic             reg2dp_conv_mode,
    output logic [1:0]       reg2dp_proc_precision,
    output logic             dp2reg_consumer,
    output logic             op_en_clr_d0,
    output logic             op_en_clr_d1,
    output logic             seq_busy,
    output logic [CNT_W-1:0] layer_cnt,
    output logic             timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_GAP} state_t;

    typedef struct packed {
        logic       conv_mode;
        logic [1:0] precision;
    } cfg_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    // Value one below all-ones: the increment out of this value reaches the limit.
    localparam logic [WDOG_W-1:0] WDOG_LAST = ~(WDOG_W'(1));

    state_t            state;
    logic [WDOG_W-1:0] wdog_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic grp_en;
    cfg_t grp_cfg;
    logic run_done;
    logic run_tout;

    // Group selected by the consumer pointer; the other group is never looked at.
    assign grp_en  = dp2reg_consumer ? reg2dp_d1_op_en : reg2dp_d0_op_en;
    assign grp_cfg = dp2reg_consumer ? cfg_t'{reg2dp_d1_conv_mode, reg2dp_d1_proc_precision}
                                     : cfg_t'{reg2dp_d0_conv_mode, reg2dp_d0_proc_precision};

    // Done has priority over a watchdog expiry in the same cycle.
    assign run_done = (state == S_RUN) && dp2reg_done;
    assign run_tout = (state == S_RUN) && !dp2reg_done && wdog_en && (wdog_cnt == WDOG_LAST);

    // Sequencer FSM with registered outputs, shadow config and counters.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state                 <= S_IDLE;
            wdog_cnt              <= '0;
            gap_cnt               <= '0;
            reg2dp_op_en          <= 1'b0;
            reg2dp_conv_mode      <= 1'b0;
            reg2dp_proc_precision <= 2'b01;
            dp2reg_consumer       <= 1'b0;
            op_en_clr_d0          <= 1'b0;
            op_en_clr_d1          <= 1'b0;
            seq_busy              <= 1'b0;
            layer_cnt             <= '0;
        end else begin
            op_en_clr_d0 <= 1'b0;
            op_en_clr_d1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grp_en) begin
                        state                 <= S_LAUNCH;
                        reg2dp_conv_mode      <= grp_cfg.conv_mode;
                        reg2dp_proc_precision <= grp_cfg.precision;
                        seq_busy              <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    state        <= S_RUN;
                    reg2dp_op_en <= 1'b1;
                end
                S_RUN: begin
                    if (run_done || run_tout) begin
                        state           <= S_GAP;
                        reg2dp_op_en    <= 1'b0;
                        op_en_clr_d0    <= ~dp2reg_consumer;
                        op_en_clr_d1    <= dp2reg_consumer;
                        dp2reg_consumer <= ~dp2reg_consumer;
                        layer_cnt       <= layer_cnt + CNT_W'(1);
                        wdog_cnt        <= '0;
                        gap_cnt         <= '0;
                    end else if (wdog_en) begin
                        wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= S_IDLE;
                        seq_busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky timeout error; a fresh timeout beats a simultaneous clear.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            timeout_err <= 1'b0;
        end else if (run_tout) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_cmac_op_seq.sv
// Bench for the CMAC layer sequencer: directed scenarios plus a randomized run
// checked cycle by cycle against an event-level model of the sequencing rules.
module tb_nv_nvdla_cmac_op_seq;

    localparam int GAP_CYCLES = 3;
    localparam int WDOG_W     = 4;
    localparam int CNT_W      = 3;

    logic             clk;
    logic             rstn;
    logic             d0_en, d1_en, d0_mode, d1_mode;
    logic [1:0]       d0_prec, d1_prec;
    logic             done, wdog_en, err_clr;
    logic             op_en, mode, cons, clr0, clr1, busy, err;
    logic [1:0]       prec;
    logic [CNT_W-1:0] cnt;

    int checks   = 0;
    int failures = 0;

    nv_nvdla_cmac_op_seq #(.GAP_CYCLES(GAP_CYCLES), .WDOG_W(WDOG_W), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk          (clk),
        .nvdla_core_rstn         (rstn),
        .reg2dp_d0_op_en         (d0_en),
        .reg2dp_d1_op_en         (d1_en),
        .reg2dp_d0_conv_mode     (d0_mode),
        .reg2dp_d1_conv_mode     (d1_mode),
        .reg2dp_d0_proc_precision(d0_prec),
        .reg2dp_d1_proc_precision(d1_prec),
        .dp2reg_done             (done),
        .wdog_en                 (wdog_en),
        .err_clr                 (err_clr),
        .reg2dp_op_en            (op_en),
        .reg2dp_conv_mode        (mode),
        .reg2dp_proc_precision   (prec),
        .dp2reg_consumer         (cons),
        .op_en_clr_d0            (clr0),
        .op_en_clr_d1            (clr1),
        .seq_busy                (busy),
        .layer_cnt               (cnt),
        .timeout_err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Observed outputs packed as {op_en, mode, prec, cons, clr0, clr1, busy, err, cnt}
    function automatic logic [11:0] obs();
        return {op_en, mode, prec, cons, clr0, clr1, busy, err, cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        d0_en = 0; d1_en = 0; d0_mode = 0; d1_mode = 0; d0_prec = 0; d1_prec = 0;
        done = 0; wdog_en = 0; err_clr = 0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // ---------------- reference model ----------------
    logic       m_op_en, m_mode, m_cons, m_clr0, m_clr1, m_err;
    logic [1:0] m_prec;
    int         m_cnt;
    bit         m_launching, m_running;
    int         m_run_wd, m_gap_left;

    task automatic model_reset();
        m_op_en = 0; m_mode = 0; m_prec = 2'b01; m_cons = 0; m_clr0 = 0; m_clr1 = 0;
        m_err = 0; m_cnt = 0; m_launching = 0; m_running = 0; m_run_wd = 0; m_gap_left = 0;
    endtask

    // One clock edge of the sequencing rules, using the inputs as driven.
    task automatic model_step();
        bit tout;
        bit fin;
        tout = 0;
        m_clr0 = 0;
        m_clr1 = 0;
        if (m_running) begin
            fin  = done || (wdog_en && (m_run_wd + 1 == (1 << WDOG_W) - 1));
            tout = fin && !done;
            if (fin) begin
                m_running = 0;
                m_op_en = 0;
                if (m_cons) m_clr1 = 1; else m_clr0 = 1;
                m_cons = !m_cons;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_run_wd = 0;
                m_gap_left = GAP_CYCLES;
            end else if (wdog_en) begin
                m_run_wd++;
            end
        end else if (m_launching) begin
            m_launching = 0;
            m_running = 1;
            m_op_en = 1;
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (m_cons ? d1_en : d0_en) begin
            m_launching = 1;
            m_mode = m_cons ? d1_mode : d0_mode;
            m_prec = m_cons ? d1_prec : d0_prec;
        end
        m_err = (m_err && !err_clr) || tout;
    endtask

    function automatic logic [11:0] model_vec();
        logic busy_e;
        busy_e = m_launching || m_running || (m_gap_left > 0);
        return {m_op_en, m_mode, m_prec, m_cons, m_clr0, m_clr1, busy_e, m_err, CNT_W'(m_cnt)};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        d0_en = 1; d1_en = 1; done = 1; wdog_en = 1; err_clr = 0;
        d0_mode = 1; d0_prec = 2;
        tick();
        tick();
        checks++;
        if (obs() !== 12'b0_0_01_0_0_0_0_0_000) begin
            failures++;
            $display("FAIL reset_values: got %b expected %b", obs(), 12'b0_0_01_0_0_0_0_0_000);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        d0_en = 1; d0_mode = 1; d0_prec = 2;
        tick();  // cycle 1
        checks++;
        if ({mode, prec, op_en, busy} !== {1'b1, 2'd2, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL basic_shadow: got mode=%0d prec=%0d op_en=%0d busy=%0d expected 1 2 0 1", mode, prec, op_en, busy);
        end
        tick();  // cycle 2
        checks++;
        if ({op_en, busy} !== 2'b11) begin
            failures++;
            $display("FAIL basic_op_en_rise: got op_en=%0d busy=%0d expected 1 1", op_en, busy);
        end
        repeat (8) tick();  // cycle 10
        done = 1;
        tick();  // cycle 11
        done = 0; d0_en = 0;
        checks++;
        if ({op_en, clr0, clr1, cons, cnt, busy} !== {1'b0, 1'b1, 1'b0, 1'b1, CNT_W'(1), 1'b1}) begin
            failures++;
            $display("FAIL basic_retire: got op_en=%0d clr0=%0d clr1=%0d cons=%0d cnt=%0d busy=%0d expected 0 1 0 1 1 1",
                     op_en, clr0, clr1, cons, cnt, busy);
        end
        tick();  // cycle 12
        checks++;
        if ({clr0, mode, prec} !== {1'b0, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL basic_pulse_and_hold: got clr0=%0d mode=%0d prec=%0d expected 0 1 2", clr0, mode, prec);
        end
        tick();  // cycle 13
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_gap_busy: got %0d expected 1", busy);
        end
        tick();  // cycle 14
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle_after_gap: got busy=%0d expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int low;
        do_reset();
        d0_en = 1; d0_mode = 0; d0_prec = 1;
        d1_en = 1; d1_mode = 1; d1_prec = 0;
        tick();
        tick();
        checks++;
        if ({op_en, mode, prec} !== {1'b1, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL b2b_first_is_d0: got op_en=%0d mode=%0d prec=%0d expected 1 0 1", op_en, mode, prec);
        end
        repeat (3) tick();
        done = 1;
        tick();
        done = 0; d0_en = 0;
        low = 1;
        for (int i = 0; i < 20 && op_en === 1'b0; i++) begin
            tick();
            if (op_en === 1'b0) low++;
        end
        checks++;
        if ({op_en, mode, prec} !== {1'b1, 1'b1, 2'd0} || low != GAP_CYCLES + 2) begin
            failures++;
            $display("FAIL b2b_second_launch: got op_en=%0d mode=%0d prec=%0d low_cycles=%0d expected 1 1 0 %0d",
                     op_en, mode, prec, low, GAP_CYCLES + 2);
        end
        done = 1;
        tick();
        done = 0; d1_en = 0;
        checks++;
        if ({cnt, clr1, clr0, cons} !== {CNT_W'(2), 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second_retire: got cnt=%0d clr1=%0d clr0=%0d cons=%0d expected 2 1 0 0", cnt, clr1, clr0, cons);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        wdog_en = 1;
        d0_en = 1;
        tick();
        tick();  // first RUN cycle
        repeat (14) tick();  // fifteenth RUN cycle
        checks++;
        if ({op_en, err} !== 2'b10) begin
            failures++;
            $display("FAIL tout_not_early: got op_en=%0d err=%0d expected 1 0", op_en, err);
        end
        tick();
        d0_en = 0;
        checks++;
        if ({err, clr0, cons, op_en, cnt} !== {1'b1, 1'b1, 1'b1, 1'b0, CNT_W'(1)}) begin
            failures++;
            $display("FAIL tout_fire: got err=%0d clr0=%0d cons=%0d op_en=%0d cnt=%0d expected 1 1 1 0 1",
                     err, clr0, cons, op_en, cnt);
        end
        err_clr = 1;
        tick();
        err_clr = 0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL tout_err_clr: got %0d expected 0", err);
        end
        d1_en = 1; d1_prec = 2;
        for (int i = 0; i < 20 && op_en === 1'b0; i++) tick();
        checks++;
        if (op_en !== 1'b1) begin
            failures++;
            $display("FAIL tout_relaunch_d1: got op_en=%0d expected 1 within 20 cycles", op_en);
        end
        repeat (14) tick();
        done = 1;
        tick();
        done = 0; d1_en = 0;
        checks++;
        if ({err, clr1, cnt, op_en} !== {1'b0, 1'b1, CNT_W'(2), 1'b0}) begin
            failures++;
            $display("FAIL tout_done_wins: got err=%0d clr1=%0d cnt=%0d op_en=%0d expected 0 1 2 0", err, clr1, cnt, op_en);
        end
    endtask

    task automatic test_spurious();
        do_reset();
        d1_en = 1;
        for (int i = 0; i < 6; i++) begin
            done = (i % 2 == 0);
            tick();
            checks++;
            if ({op_en, busy, cnt, clr0, clr1, cons} !== {1'b0, 1'b0, CNT_W'(0), 1'b0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL spurious_idle[%0d]: got op_en=%0d busy=%0d cnt=%0d clr0=%0d clr1=%0d cons=%0d expected all 0",
                         i, op_en, busy, cnt, clr0, clr1, cons);
            end
        end
        done = 0; d1_en = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        d0_en = 1; d0_mode = 1; d0_prec = 2;
        repeat (4) tick();
        #3;
        rstn = 1'b0;
        #1;
        checks++;
        if (obs() !== 12'b0_0_01_0_0_0_0_0_000) begin
            failures++;
            $display("FAIL async_reset_mid_run: got %b expected %b", obs(), 12'b0_0_01_0_0_0_0_0_000);
        end
        #1;
        rstn = 1'b1;
        tick();
        checks++;
        if ({op_en, busy, mode} !== 3'b011) begin
            failures++;
            $display("FAIL async_relaunch_launch: got op_en=%0d busy=%0d mode=%0d expected 0 1 1", op_en, busy, mode);
        end
        tick();
        checks++;
        if (op_en !== 1'b1) begin
            failures++;
            $display("FAIL async_relaunch_run: got op_en=%0d expected 1", op_en);
        end
        do_reset();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            d0_en   = ($urandom % 4) != 0;
            d1_en   = ($urandom % 4) != 0;
            d0_mode = $urandom % 2;
            d1_mode = $urandom % 2;
            d0_prec = 2'($urandom_range(2, 0));
            d1_prec = 2'($urandom_range(2, 0));
            done    = ($urandom % 10) == 0;
            wdog_en = ($urandom % 8) != 0;
            err_clr = ($urandom % 16) == 0;
            @(posedge clk);
            model_step();
            #1;
            checks++;
            if (obs() !== model_vec()) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle[%0d]: got %b expected %b (op_en,mode,prec,cons,clr0,clr1,busy,err,cnt)",
                             cyc, obs(), model_vec());
            end
        end
        done = 0; d0_en = 0; d1_en = 0; err_clr = 0;
    endtask

    initial begin
        rstn = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_spurious();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
